// File: rtl/seg7_fade_driver_pkg.sv
// Shared definitions for the faded 7-segment display stage: FSM encoding,
// BCD range and segment bit positions.
package seg7_fade_driver_pkg;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment vector order is {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic bcd_valid(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/seg7_fade_driver_seg7.sv
// BCD to 7-segment decoder, active-high segments {g,f,e,d,c,b,a};
// codes above 9 decode to blank.
module seg7_fade_driver_seg7
  import seg7_fade_driver_pkg::*;
(
  input  logic [3:0] counter,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_OFF;
    case (counter)
      4'd0: segments = 7'h3F;
      4'd1: segments = 7'h06;
      4'd2: segments = 7'h5B;
      4'd3: segments = 7'h4F;
      4'd4: segments = 7'h66;
      4'd5: segments = 7'h6D;
      4'd6: segments = 7'h7D;
      4'd7: segments = 7'h07;
      4'd8: segments = 7'h7F;
      4'd9: segments = 7'h6F;
      default: segments = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_fade_driver.sv
// Display stage: accepts BCD digits over valid/ready, PWM-dims the segments and
// cross-fades (out, swap, in) whenever the shown digit changes.
module seg7_fade_driver
  import seg7_fade_driver_pkg::*;
#(
  parameter int          PWM_BITS = 4,
  parameter logic [23:0] FADE_DIV = 24'd2048
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_digit,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [6:0]          segments,
  output logic                fading
);

  localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [23:0]         FADE_LAST = FADE_DIV - 24'd1;

  state_e                state_q, state_d;
  logic [3:0]            shown_q, shown_d;
  logic [3:0]            pending_q, pending_d;
  logic [PWM_BITS-1:0]   level_q, level_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [23:0]           timer_q, timer_d;
  logic [6:0]            segments_q;
  logic [6:0]            seg_raw;
  logic                  accept;
  logic                  timer_done;

  seg7_fade_driver_seg7 u_seg7 (
    .counter  (shown_q),
    .segments (seg_raw)
  );

  // rst_n gates ready so nothing is offered while the block is held in reset
  assign in_ready   = ena && rst_n && (state_q == SHOW);
  assign accept     = in_valid && in_ready;
  assign timer_done = (timer_q == FADE_LAST);
  assign fading     = (state_q != SHOW);
  assign segments   = segments_q;

  always_comb begin
    state_d   = state_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    level_d   = level_q;
    timer_d   = timer_q;
    if (ena) begin
      case (state_q)
        SHOW: begin
          level_d = brightness;
          if (accept && (in_digit != shown_q)) begin
            pending_d = in_digit;
            timer_d   = '0;
            state_d   = FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (level_q == '0) begin
            shown_d = pending_q;
            timer_d = '0;
            state_d = FADE_IN;
          end else if (timer_done) begin
            timer_d = '0;
            level_d = level_q - PWM_BITS'(1);
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        FADE_IN: begin
          // >= also catches a brightness lowered mid-fade and clamps to it
          if (level_q >= brightness) begin
            level_d = brightness;
            state_d = SHOW;
          end else if (timer_done) begin
            timer_d = '0;
            level_d = level_q + PWM_BITS'(1);
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        default: state_d = SHOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SHOW;
      shown_q   <= 4'd0;
      pending_q <= 4'd0;
      level_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else if (ena) begin
      pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments_q <= SEG_OFF;
    end else begin
      segments_q <= (bcd_valid(shown_q) && (pwm_cnt_q < level_q)) ? seg_raw : SEG_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_fade_driver.sv
// Directed bench for seg7_fade_driver (PWM_BITS=4, FADE_DIV=2) with an
// expectation queue popped at each observation point.
module tb_seg7_fade_driver;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_digit;
  logic [3:0] brightness;
  logic [6:0] segments;
  logic       fading;

  seg7_fade_driver #(.PWM_BITS(4), .FADE_DIV(24'd2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_digit   (in_digit),
    .brightness (brightness),
    .segments   (segments),
    .fading     (fading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %0h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
    $display("check %-14s observed %0h expected %0h", e.tag, obs, e.val);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_seg(input int n, input logic [6:0] pat, output int lit, output int dark);
    lit  = 0;
    dark = 0;
    repeat (n) begin
      @(negedge clk);
      if (segments === pat) lit++;
      if (segments === 7'h00) dark++;
    end
  endtask

  // Waits (bounded) for ready, presents the digit for one cycle; returns at the
  // negedge just after the accepting edge.
  task automatic send(input logic [3:0] d);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    expect_val("send_ready", 1);
    check({31'd0, in_ready});
    in_valid = 1'b1;
    in_digit = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic count_fading(output int cnt);
    cnt = 0;
    while (fading === 1'b1 && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  int lit, dark, cnt;

  initial begin
    rst_n      = 1'b1;
    ena        = 1'b1;
    in_valid   = 1'b0;
    in_digit   = 4'd0;
    brightness = 4'd15;

    // 1: asynchronous reset mid-cycle, then release at full brightness
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    expect_val("rst_seg", 7'h00);  check({25'd0, segments});
    expect_val("rst_fading", 0);   check({31'd0, fading});
    expect_val("rst_ready", 0);    check({31'd0, in_ready});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_val("rel_seg_p1", 7'h00); check({25'd0, segments});
    @(negedge clk);
    expect_val("rel_seg_p2", 7'h3F); check({25'd0, segments});
    count_seg(15, 7'h3F, lit, dark);
    expect_val("full_lit", 15);    check(lit);

    // 2: PWM duty at brightness 8
    brightness = 4'd8;
    cyc(2);
    count_seg(15, 7'h3F, lit, dark);
    expect_val("duty8_lit", 8);    check(lit);
    expect_val("duty8_dark", 7);   check(dark);

    // 4: same digit is accepted without a fade
    brightness = 4'd15;
    cyc(1);
    send(4'd0);
    expect_val("same_fading", 0);  check({31'd0, fading});
    expect_val("same_ready", 1);   check({31'd0, in_ready});

    // 3: fade swap to 5 at brightness 3
    brightness = 4'd3;
    cyc(1);
    send(4'd5);
    expect_val("swap_fading", 1);  check({31'd0, fading});
    count_fading(cnt);
    expect_val("swap_cycles", 14); check(cnt);
    expect_val("swap_ready", 1);   check({31'd0, in_ready});
    brightness = 4'd15;
    cyc(2);
    expect_val("swap_digit5", 7'h6D); check({25'd0, segments});

    // 5: out-of-range digit blanks, then digit 4 shows
    brightness = 4'd3;
    cyc(1);
    send(4'd12);
    count_fading(cnt);
    expect_val("oor_cycles", 14);  check(cnt);
    brightness = 4'd15;
    cyc(2);
    count_seg(15, 7'h00, lit, dark);
    expect_val("oor_dark", 15);    check(dark);
    send(4'd4);
    count_fading(cnt);
    expect_val("d4_cycles", 62);   check(cnt);
    cyc(2);
    expect_val("d4_seg", 7'h66);   check({25'd0, segments});

    // 6a: brightness 0 still swaps, in two cycles
    brightness = 4'd0;
    cyc(1);
    send(4'd7);
    count_fading(cnt);
    expect_val("b0_cycles", 2);    check(cnt);
    brightness = 4'd15;
    cyc(2);
    expect_val("b0_digit7", 7'h07); check({25'd0, segments});

    // 6b: reset during FADE_OUT of 9 returns to digit 0 in SHOW
    send(4'd9);
    cyc(3);
    expect_val("mid_fading", 1);   check({31'd0, fading});
    #2 rst_n = 1'b0;
    #1;
    expect_val("mid_rst_seg", 7'h00); check({25'd0, segments});
    expect_val("mid_rst_fad", 0);     check({31'd0, fading});
    expect_val("mid_rst_rdy", 0);     check({31'd0, in_ready});
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    expect_val("mid_digit0", 7'h3F); check({25'd0, segments});
    expect_val("mid_ready", 1);      check({31'd0, in_ready});

    // 6c: ena=0 freezes the fade for 20 cycles
    brightness = 4'd3;
    cyc(1);
    send(4'd2);
    cnt = 0;
    while (fading === 1'b1 && cnt < 300) begin
      cnt++;
      if (cnt == 3)  ena = 1'b0;
      if (cnt == 23) ena = 1'b1;
      @(negedge clk);
    end
    expect_val("frz_cycles", 34);  check(cnt);

    // 6d: ena=0 in SHOW drops ready, ignores input and freezes PWM
    brightness = 4'd15;
    cyc(2);
    ena = 1'b0;
    #1;
    expect_val("ena0_ready", 0);   check({31'd0, in_ready});
    in_valid = 1'b1;
    in_digit = 4'd8;
    cyc(5);
    in_valid = 1'b0;
    ena = 1'b1;
    cyc(1);
    expect_val("ena0_nofade", 0);  check({31'd0, fading});
    cyc(1);
    expect_val("ena0_digit2", 7'h5B); check({25'd0, segments});
    brightness = 4'd8;
    cyc(3);
    ena = 1'b0;
    cyc(1);
    count_seg(15, 7'h5B, lit, dark);
    expect_val("pwm_frozen", 1);   check({31'd0, (lit == 0 || lit == 15)});
    ena = 1'b1;

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
